// File: rtl/wired_fpu_age_iq_if.sv
// Interface bundle for wired_fpu_age_iq: dispatch, CDB snoop, FPU request/result and CDB output.
// slave is the issue-queue side, master the surrounding pipeline (or a bench).
interface wired_fpu_age_iq_if #(
  parameter int unsigned CDB_CNT   = 2,
  parameter int unsigned RID_W     = 6,
  parameter int unsigned PAYLOAD_W = 16
);
  logic                            flush_i;
  logic                            p_valid_i;
  logic                            p_ready_o;
  logic [PAYLOAD_W-1:0]            p_payload_i;
  logic [RID_W-1:0]                p_wid_i;
  logic [2:0]                      p_src_rdy_i;
  logic [2:0][RID_W-1:0]           p_src_rid_i;
  logic [2:0][31:0]                p_src_data_i;
  logic [CDB_CNT-1:0]              cdb_valid_i;
  logic [CDB_CNT-1:0][RID_W-1:0]   cdb_wid_i;
  logic [CDB_CNT-1:0][31:0]        cdb_wdata_i;
  logic                            ex_valid_o;
  logic                            ex_ready_i;
  logic [PAYLOAD_W-1:0]            ex_payload_o;
  logic [RID_W-1:0]                ex_wid_o;
  logic [2:0][31:0]                ex_r_o;
  logic                            ex_valid_i;
  logic                            ex_ready_o;
  logic [RID_W-1:0]                ex_wid_i;
  logic [31:0]                     ex_result_i;
  logic [4:0]                      ex_fpexcp_i;
  logic                            cdb_valid_o;
  logic                            cdb_ready_i;
  logic [RID_W-1:0]                cdb_wid_o;
  logic [31:0]                     cdb_wdata_o;
  logic [4:0]                      cdb_fpexcp_o;

  modport slave (
    input  flush_i, p_valid_i, p_payload_i, p_wid_i, p_src_rdy_i, p_src_rid_i, p_src_data_i,
    input  cdb_valid_i, cdb_wid_i, cdb_wdata_i, ex_ready_i,
    input  ex_valid_i, ex_wid_i, ex_result_i, ex_fpexcp_i, cdb_ready_i,
    output p_ready_o, ex_valid_o, ex_payload_o, ex_wid_o, ex_r_o, ex_ready_o,
    output cdb_valid_o, cdb_wid_o, cdb_wdata_o, cdb_fpexcp_o
  );

  modport master (
    output flush_i, p_valid_i, p_payload_i, p_wid_i, p_src_rdy_i, p_src_rid_i, p_src_data_i,
    output cdb_valid_i, cdb_wid_i, cdb_wdata_i, ex_ready_i,
    output ex_valid_i, ex_wid_i, ex_result_i, ex_fpexcp_i, cdb_ready_i,
    input  p_ready_o, ex_valid_o, ex_payload_o, ex_wid_o, ex_r_o, ex_ready_o,
    input  cdb_valid_o, cdb_wid_o, cdb_wdata_o, cdb_fpexcp_o
  );
endinterface

// File: rtl/wired_fpu_age_iq.sv
// Out-of-order FPU issue queue with CDB-snooping wakeup, one issue register and a result FIFO.
// Define WIRED_FPU_IQ_AGE_EN for age-matrix (oldest-first) select; otherwise lowest index wins.
module wired_fpu_age_iq #(
  parameter int unsigned IQ_SIZE   = 4,
  parameter int unsigned CDB_CNT   = 2,
  parameter int unsigned RID_W     = 6,
  parameter int unsigned PAYLOAD_W = 16,
  parameter int unsigned OUT_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  wired_fpu_age_iq_if.slave bus
);
  localparam int unsigned IdxW  = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;
  localparam int unsigned CntW  = $clog2(IQ_SIZE + 1);
  localparam int unsigned PtrW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned OcntW = $clog2(OUT_DEPTH + 1);

  logic [IQ_SIZE-1:0]                 valid_q, valid_d;
  logic [IQ_SIZE-1:0][PAYLOAD_W-1:0]  payload_q, payload_d;
  logic [IQ_SIZE-1:0][RID_W-1:0]      wid_q, wid_d;
  logic [IQ_SIZE-1:0][2:0]            rdy_q, rdy_d;
  logic [IQ_SIZE-1:0][2:0][RID_W-1:0] rid_q, rid_d;
  logic [IQ_SIZE-1:0][2:0][31:0]      data_q, data_d;
  logic [CntW-1:0]                    free_q, free_d;
  logic                               p_ready_q;

  logic [IQ_SIZE-1:0] elig;
  logic [IdxW-1:0]    sel_idx, alloc_idx;
  logic               dispatch, iss_load, issue_fire;

  logic                 ex_valid_q;
  logic [PAYLOAD_W-1:0] ex_payload_q;
  logic [RID_W-1:0]     ex_wid_q;
  logic [2:0][31:0]     ex_r_q;

  assign dispatch   = bus.p_valid_i & p_ready_q;
  assign iss_load   = ~ex_valid_q | bus.ex_ready_i;
  assign issue_fire = iss_load & (|elig);

  always_comb begin
    elig = '0;
    for (int i = 0; i < IQ_SIZE; i++) elig[i] = valid_q[i] & (&rdy_q[i]);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = IQ_SIZE - 1; i >= 0; i--) if (!valid_q[i]) alloc_idx = IdxW'(i);
  end

`ifdef WIRED_FPU_IQ_AGE_EN
  // age_q[i][j]: entry i is older than entry j
  logic [IQ_SIZE-1:0][IQ_SIZE-1:0] age_q, age_d;

  always_comb begin
    logic older;
    older   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      older = 1'b0;
      for (int j = 0; j < IQ_SIZE; j++) older = older | (elig[j] & age_q[j][i]);
      if (elig[i] && !older) sel_idx = IdxW'(i);
    end
  end

  always_comb begin
    age_d = age_q;
    if (dispatch) begin
      age_d[alloc_idx] = '0;
      for (int j = 0; j < IQ_SIZE; j++) if (valid_q[j]) age_d[j][alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) age_q <= '0;
    else                    age_q <= age_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = IQ_SIZE - 1; i >= 0; i--) if (elig[i]) sel_idx = IdxW'(i);
  end
`endif

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    wid_d     = wid_q;
    rdy_d     = rdy_q;
    rid_d     = rid_q;
    data_d    = data_q;
    // Descending bus scan so the lowest matching bus index is the one that sticks.
    for (int i = 0; i < IQ_SIZE; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (valid_q[i] && !rdy_q[i][s]) begin
          for (int b = CDB_CNT - 1; b >= 0; b--) begin
            if (bus.cdb_valid_i[b] && (bus.cdb_wid_i[b] == rid_q[i][s])) begin
              rdy_d[i][s]  = 1'b1;
              data_d[i][s] = bus.cdb_wdata_i[b];
            end
          end
        end
      end
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (dispatch) begin
      valid_d[alloc_idx]   = 1'b1;
      payload_d[alloc_idx] = bus.p_payload_i;
      wid_d[alloc_idx]     = bus.p_wid_i;
      rdy_d[alloc_idx]     = bus.p_src_rdy_i;
      rid_d[alloc_idx]     = bus.p_src_rid_i;
      data_d[alloc_idx]    = bus.p_src_data_i;
      for (int s = 0; s < 3; s++) begin
        if (!bus.p_src_rdy_i[s]) begin
          for (int b = CDB_CNT - 1; b >= 0; b--) begin
            if (bus.cdb_valid_i[b] && (bus.cdb_wid_i[b] == bus.p_src_rid_i[s])) begin
              rdy_d[alloc_idx][s]  = 1'b1;
              data_d[alloc_idx][s] = bus.cdb_wdata_i[b];
            end
          end
        end
      end
    end
  end

  assign free_d = free_q - CntW'(dispatch) + CntW'(issue_fire);

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      valid_q   <= '0;
      free_q    <= CntW'(IQ_SIZE);
      p_ready_q <= 1'b1;
    end else begin
      valid_q   <= valid_d;
      free_q    <= free_d;
      p_ready_q <= (free_d != '0);
    end
  end

  // Entry contents are only meaningful under valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
    wid_q     <= wid_d;
    rdy_q     <= rdy_d;
    rid_q     <= rid_d;
    data_q    <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_wid_q     <= '0;
      ex_r_q       <= '0;
    end else if (iss_load) begin
      ex_valid_q <= issue_fire;
      if (issue_fire) begin
        ex_payload_q <= payload_q[sel_idx];
        ex_wid_q     <= wid_q[sel_idx];
        ex_r_q       <= data_q[sel_idx];
      end
    end
  end

  logic [OUT_DEPTH-1:0][RID_W-1:0] fwid_q;
  logic [OUT_DEPTH-1:0][31:0]      fres_q;
  logic [OUT_DEPTH-1:0][4:0]       fexc_q;
  logic [PtrW-1:0]                 wptr_q, rptr_q;
  logic [OcntW-1:0]                ocnt_q;
  logic                            f_full, f_empty, f_push, f_pop;

  assign f_full  = (ocnt_q == OcntW'(OUT_DEPTH));
  assign f_empty = (ocnt_q == '0);
  assign f_push  = bus.ex_valid_i & ~f_full;
  assign f_pop   = ~f_empty & bus.cdb_ready_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      fwid_q <= '0;
      fres_q <= '0;
      fexc_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ocnt_q <= '0;
    end else begin
      if (f_push) begin
        fwid_q[wptr_q] <= bus.ex_wid_i;
        fres_q[wptr_q] <= bus.ex_result_i;
        fexc_q[wptr_q] <= bus.ex_fpexcp_i;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (f_pop) rptr_q <= ptr_inc(rptr_q);
      ocnt_q <= ocnt_q + OcntW'(f_push) - OcntW'(f_pop);
    end
  end

  assign bus.p_ready_o    = p_ready_q;
  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.ex_payload_o = ex_payload_q;
  assign bus.ex_wid_o     = ex_wid_q;
  assign bus.ex_r_o       = ex_r_q;
  assign bus.ex_ready_o   = ~f_full;
  assign bus.cdb_valid_o  = ~f_empty;
  assign bus.cdb_wid_o    = fwid_q[rptr_q];
  assign bus.cdb_wdata_o  = fres_q[rptr_q];
  assign bus.cdb_fpexcp_o = fexc_q[rptr_q];
endmodule
